// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_e;

   localparam int unsigned SUB_WIDTH_DEFAULT = 8;

endpackage : serial_sub_pkg

// File: rtl/FS.sv
// Combinational full-subtractor cell: d = a - b - b_in, with borrow out.
module FS (
   input  logic a,
   input  logic b,
   input  logic b_in,
   output logic d,
   output logic b_out
);

   assign d     = a ^ b ^ b_in;
   assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule : FS

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor (a - b - b_in), LSB first, one FS cell plus a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   sub_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             fs_d;
   logic             fs_bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   FS u_fs (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .b_in  (br_q),
      .d     (fs_d),
      .b_out (fs_bout)
   );

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_ready_q && in_valid) begin
               a_d     = a;
               b_d     = b;
               br_d    = b_in;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = (res_q >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));
            br_d  = fs_bout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
               // borrow into the MSB step xor borrow out of it
               ovf_d   = br_q ^ fs_bout;
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so reset holds in_ready low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         br_q        <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         br_q        <= br_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
`ifdef SERIAL_SUB_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = res_q;
   assign b_out     = br_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         b_in = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         b_out;
   logic         ovf_w;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .b_out     (b_out)
`ifdef SERIAL_SUB_OVF_EN
     ,.ovf       (ovf_w)
`endif
   );

`ifndef SERIAL_SUB_OVF_EN
   assign ovf_w = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain integer arithmetic on the operands
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                 output logic [W-1:0] md, output logic mbo, output logic mov);
      int r;
      int s;
      r   = int'(ma) - int'(mb) - int'(mbin);
      s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      md  = W'(r);
      mbo = (r < 0);
      mov = (s < -128) || (s > 127);
   endfunction

   // Drives one transaction, returns the result, latency and accept cycle
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         output logic [W-1:0] rd, output logic rbo, output logic rov,
                         output int lat, output int acc, output bit tmo);
      int n;
      n = 0;
      tmo = 1'b0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready) tmo = 1'b1;
      a = ta; b = tb; b_in = tbin; in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      if (!out_valid) tmo = 1'b1;
      rd = diff; rbo = b_out; rov = ovf_w;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || diff !== 8'h00 || b_out !== 1'b0 || ovf_w !== 1'b0) begin
         bad++;
         $display("FAIL reset_values: got rdy=%b vld=%b diff=%h bo=%b ovf=%b, want 0 0 00 0 0",
                  in_ready, out_valid, diff, b_out, ovf_w);
      end
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed;
      logic [W-1:0] va [4] = '{8'h35, 8'h00, 8'h80, 8'h10};
      logic [W-1:0] vb [4] = '{8'h12, 8'h01, 8'h01, 8'h0F};
      logic         vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [W-1:0] ed [4] = '{8'h23, 8'hFF, 8'h7F, 8'h00};
      logic         eb [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic         eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [W-1:0] rd;
      logic rbo, rov;
      int lat, acc;
      bit tmo;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], vc[i], rd, rbo, rov, lat, acc, tmo);
         total++;
         if (tmo || rd !== ed[i] || rbo !== eb[i]) begin
            bad++;
            $display("FAIL directed_%0d: got diff=%h bo=%b tmo=%0d, want diff=%h bo=%b",
                     i, rd, rbo, tmo, ed[i], eb[i]);
         end
         total++;
         if (lat != 8) begin
            bad++;
            $display("FAIL directed_latency_%0d: got %0d want 8", i, lat);
         end
`ifdef SERIAL_SUB_OVF_EN
         total++;
         if (rov !== eo[i]) begin
            bad++;
            $display("FAIL directed_ovf_%0d: got %b want %b", i, rov, eo[i]);
         end
`endif
      end
   endtask

   task automatic test_random;
      logic [W-1:0] ta, tb, rd, md;
      logic tbin, rbo, rov, mbo, mov;
      int lat, acc;
      bit tmo;
      for (int i = 0; i < 40; i++) begin
         ta = W'($urandom); tb = W'($urandom); tbin = 1'($urandom_range(0, 1));
         model(ta, tb, tbin, md, mbo, mov);
         run_op(ta, tb, tbin, rd, rbo, rov, lat, acc, tmo);
         total++;
         if (tmo || rd !== md || rbo !== mbo || lat != 8) begin
            bad++;
            $display("FAIL random_%0d a=%h b=%h bin=%b: got diff=%h bo=%b lat=%0d, want diff=%h bo=%b lat=8",
                     i, ta, tb, tbin, rd, rbo, lat, md, mbo);
         end
`ifdef SERIAL_SUB_OVF_EN
         total++;
         if (rov !== mov) begin
            bad++;
            $display("FAIL random_ovf_%0d: got %b want %b", i, rov, mov);
         end
`endif
      end
   endtask

   task automatic test_backpressure;
      logic [W-1:0] hd, md, rd;
      logic hbo, hov, mbo, mov, rbo, rov;
      int n, lat, acc;
      bit tmo;
      a = 8'h9C; b = 8'h37; b_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      model(8'h9C, 8'h37, 1'b1, md, mbo, mov);
      total++;
      if (!out_valid || diff !== md || b_out !== mbo) begin
         bad++;
         $display("FAIL bp_result: got vld=%b diff=%h bo=%b, want 1 %h %b", out_valid, diff, b_out, md, mbo);
      end
      hd = diff; hbo = b_out; hov = ovf_w;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom); b_in = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== hd || b_out !== hbo || ovf_w !== hov) begin
            bad++;
            $display("FAIL bp_hold_%0d: got vld=%b rdy=%b diff=%h bo=%b, want 1 0 %h %b",
                     i, out_valid, in_ready, diff, b_out, hd, hbo);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
      end
      model(8'h44, 8'h45, 1'b0, md, mbo, mov);
      run_op(8'h44, 8'h45, 1'b0, rd, rbo, rov, lat, acc, tmo);
      total++;
      if (tmo || rd !== md || rbo !== mbo || lat != 8) begin
         bad++;
         $display("FAIL bp_next_op: got diff=%h bo=%b lat=%0d, want %h %b 8", rd, rbo, lat, md, mbo);
      end
   endtask

   task automatic test_reset_mid_shift;
      logic [W-1:0] rd;
      logic rbo, rov;
      int lat, acc;
      bit tmo;
      a = 8'hC3; b = 8'h5A; b_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || diff !== 8'h00 || b_out !== 1'b0 || ovf_w !== 1'b0) begin
         bad++;
         $display("FAIL midreset_values: got rdy=%b vld=%b diff=%h bo=%b ovf=%b, want 0 0 00 0 0",
                  in_ready, out_valid, diff, b_out, ovf_w);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL midreset_idle: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
      end
      run_op(8'h05, 8'h03, 1'b0, rd, rbo, rov, lat, acc, tmo);
      total++;
      if (tmo || rd !== 8'h02 || rbo !== 1'b0 || lat != 8) begin
         bad++;
         $display("FAIL midreset_next_op: got diff=%h bo=%b lat=%0d, want 02 0 8", rd, rbo, lat);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] rd, md;
      logic rbo, rov, mbo, mov;
      int lat, acc0, acc1;
      bit tmo;
      run_op(8'h01, 8'h02, 1'b0, rd, rbo, rov, lat, acc0, tmo);
      model(8'hF0, 8'h0F, 1'b1, md, mbo, mov);
      run_op(8'hF0, 8'h0F, 1'b1, rd, rbo, rov, lat, acc1, tmo);
      total++;
      if (acc1 - acc0 != W + 2) begin
         bad++;
         $display("FAIL b2b_interval: got %0d want %0d", acc1 - acc0, W + 2);
      end
      total++;
      if (tmo || rd !== md || rbo !== mbo) begin
         bad++;
         $display("FAIL b2b_result: got diff=%h bo=%b, want %h %b", rd, rbo, md, mbo);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_shift();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b - b_in` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the sequential, inverse-operation counterpart to the team's combinational full-adder cells. It sits beside the arithmetic datapath where area matters more than latency. Operands enter and results leave through valid/ready handshakes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 1.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `in_valid`  input  1: operands and borrow-in are valid.
- `in_ready`  output  1: block can accept operands.
- `a`  input  WIDTH: minuend.
- `b`  input  WIDTH: subtrahend.
- `b_in`  input  1: borrow-in.
- `out_valid`  output  1: result is valid.
- `out_ready`  input  1: consumer accepts the result.
- `diff`  output  WIDTH: difference, `(a - b - b_in) mod 2^WIDTH`.
- `b_out`  output  1: borrow out of the MSB.
- `ovf`  output  1: signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- The FSM has states IDLE, SHIFT and DONE.
- **IDLE:**
  - `in_ready`=1.
  - When `in_valid`=1: latch `a` and `b` into shift registers, load the borrow flop with `b_in`, clear the bit counter, and go to SHIFT.
- **SHIFT:**
  - `in_ready`=0. Each cycle processes bit 0 of both shift registers (`a0`, `b0`) together with the current borrow `br`.
  - Difference bit: `d = a0 ^ b0 ^ br`.
  - Next borrow: `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - The `a` and `b` registers shift right. `d` enters the result register at the MSB and the result shifts right.
  - The counter increments. At counter == WIDTH-1, go to DONE.
- **DONE:**
  - `out_valid`=1.
  - `diff` is the result register. `b_out` is the final borrow.
  - All outputs are held stable while `out_ready`=0.
  - When `out_ready`=1, go to IDLE.
- `in_valid` is ignored outside IDLE. Operands are sampled only on the accepting edge, so later changes to `a`/`b` have no effect.
- The counter is `max(1, $clog2(WIDTH))` bits wide. WIDTH=1 spends exactly one cycle in SHIFT.
- Reset (asserted at any time, including mid-SHIFT) immediately forces IDLE. It clears every register and discards any in-flight operation.
- Reset values:
  - `in_ready`=0 while `rst_n`=0, and 1 from the first clock after release.
  - `out_valid`=0, `diff`=0, `b_out`=0, `ovf`=0.

## Timing
- The accepting edge E0 is the edge where IDLE sees `in_valid`=1.
- SHIFT occupies the WIDTH cycles after E0.
- `out_valid` rises after edge E0+WIDTH, giving a latency of WIDTH cycles.
- Minimum initiation interval is WIDTH+2 cycles: DONE is left on the `out_ready` edge, and IDLE then accepts on the next edge.
- There is no combinational path from the inputs to any output. All outputs are registered or decoded from the state.

## Configuration
- **With `SERIAL_SUB_OVF_EN` defined:**
  - The `ovf` port exists.
  - The borrow entering the MSB step is captured.
  - `ovf = borrow_into_msb ^ b_out`, valid in DONE.
- **Without the macro:** the `ovf` port and the capture flop are absent. Behaviour is otherwise identical.

## Structure
- Package `serial_sub_pkg` holds:
  - the state enum `sub_state_e` (IDLE, SHIFT, DONE);
  - the default width constant `SUB_WIDTH_DEFAULT = 8`.
- Sub-module `FS`: a combinational full subtractor with inputs (`a`, `b`, `b_in`) and outputs (`d`, `b_out`), instantiated once for the per-bit cell.
- The top level contains the FSM, the three shift registers, the counter and the borrow flop.

## Test plan
All scenarios use WIDTH=8.
- `a`=0x35, `b`=0x12, `b_in`=0 → `diff`=0x23, `b_out`=0. `out_valid` rises exactly 8 cycles after the accepting edge.
- `a`=0x00, `b`=0x01, `b_in`=0 → `diff`=0xFF, `b_out`=1. With OVF_EN, `ovf`=0.
- `a`=0x80, `b`=0x01, `b_in`=0 → `diff`=0x7F, `b_out`=0. With OVF_EN, `ovf`=1.
- `a`=0x10, `b`=0x0F, `b_in`=1 → `diff`=0x00, `b_out`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → outputs stable and `in_ready`=0. A concurrent `in_valid` with new operands is ignored. Then `out_ready`=1 → IDLE on the next edge, and the next op is accepted one edge later.
- Reset mid-SHIFT at bit 4 → all outputs are 0 and the state is IDLE. A following op `a`=0x05, `b`=0x03 → `diff`=0x02, `b_out`=0.
